// File: rtl/controle_escrita_mem.sv
// Store-path engine: full-word stores go straight to memory, byte/halfword
// stores do a read-modify-write against a word-wide synchronous memory.
module controle_escrita_mem #(
    parameter int LAT_LEITURA = 1,
    parameter int LARGURA_END = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valido,
    output logic                   req_pronto,
    input  logic [LARGURA_END-1:0] endereco,
    input  logic [31:0]            dadoReg,
    input  logic [1:0]             tamanho,
    output logic [LARGURA_END-1:0] mem_end,
    output logic                   mem_le,
    input  logic [31:0]            mem_lerDado,
    output logic                   mem_escreve,
    output logic [31:0]            mem_escreveDado,
    output logic                   concluido,
    output logic                   erro
);

    typedef enum logic [2:0] {
        OCIOSO,
        LEITURA,
        ESPERA,
        ESCRITA,
        ERRO
    } estado_t;

    localparam logic [1:0] TAM_BYTE = 2'b00;
    localparam logic [1:0] TAM_MEIA = 2'b01;
    localparam logic [1:0] TAM_PALAVRA = 2'b10;

    estado_t     estado, prox_estado;
    logic [1:0]  pos_q;
    logic [15:0] dado_q;
    logic [1:0]  tam_q;
    logic [1:0]  cnt;
    logic        aceita;
    logic        req_erro;
    logic        ultimo_ciclo;
    logic [31:0] dado_mesclado;

    assign aceita       = req_valido && (estado == OCIOSO);
    assign ultimo_ciclo = (cnt == 2'(LAT_LEITURA - 1));

    // Misaligned halfword/word or reserved size is rejected without touching memory.
    assign req_erro = (tamanho == 2'b11)
                   || ((tamanho == TAM_MEIA) && endereco[0])
                   || ((tamanho == TAM_PALAVRA) && (endereco[1:0] != 2'b00));

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        dado_mesclado = mem_lerDado;
        if (tam_q == TAM_MEIA) begin
            if (pos_q[1]) dado_mesclado[31:16] = dado_q;
            else          dado_mesclado[15:0]  = dado_q;
        end else begin
            case (pos_q)
                2'd0:    dado_mesclado[7:0]   = dado_q[7:0];
                2'd1:    dado_mesclado[15:8]  = dado_q[7:0];
                2'd2:    dado_mesclado[23:16] = dado_q[7:0];
                default: dado_mesclado[31:24] = dado_q[7:0];
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO: begin
                if (req_valido) begin
                    if (req_erro)                    prox_estado = ERRO;
                    else if (tamanho == TAM_PALAVRA) prox_estado = ESCRITA;
                    else                             prox_estado = LEITURA;
                end
            end
            LEITURA: prox_estado = ESPERA;
            ESPERA:  if (ultimo_ciclo) prox_estado = ESCRITA;
            ESCRITA: prox_estado = OCIOSO;
            ERRO:    prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        req_pronto  = 1'b0;
        mem_le      = 1'b0;
        mem_escreve = 1'b0;
        concluido   = 1'b0;
        erro        = 1'b0;
        case (estado)
            OCIOSO:  req_pronto = 1'b1;
            LEITURA: mem_le     = 1'b1;
            ESCRITA: begin
                mem_escreve = 1'b1;
                concluido   = 1'b1;
            end
            ERRO:    erro = 1'b1;
            default: ;
        endcase
    end

    // NOTE: data registers are reset too, so an aborted request leaves no stale address or data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q           <= '0;
            dado_q          <= '0;
            tam_q           <= '0;
            cnt             <= '0;
            mem_end         <= '0;
            mem_escreveDado <= '0;
        end else begin
            if (aceita) begin
                pos_q  <= endereco[1:0];
                dado_q <= dadoReg[15:0];
                tam_q  <= tamanho;
                cnt    <= '0;
                if (!req_erro) mem_end <= {endereco[LARGURA_END-1:2], 2'b00};
                if (!req_erro && (tamanho == TAM_PALAVRA)) mem_escreveDado <= dadoReg;
            end
            // Read data is sampled at the end of the last wait cycle.
            if (estado == ESPERA) begin
                cnt <= cnt + 2'd1;
                if (ultimo_ciclo) mem_escreveDado <= dado_mesclado;
            end
        end
    end

    logic unused_tam;
    assign unused_tam = (TAM_BYTE == 2'b00);

endmodule

// File: tb/tb_controle_escrita_mem.sv
// Bench for controle_escrita_mem: two instances (read latency 1 and 3) driven by
// the same directed store list, checked every cycle against a schedule-based model.
module tb_controle_escrita_mem;

    localparam int NC = 2048;
    localparam int NV = 12;

    typedef struct {
        logic [31:0] a;
        logic [31:0] dt;
        logic [1:0]  sz;
        bit          b2b;
        bit          litv;
        logic [31:0] la;
        logic [31:0] ld;
    } vec_t;

    logic        clk;
    logic        rst_n           [2];
    logic        req_valido      [2];
    logic        req_pronto      [2];
    logic [31:0] endereco        [2];
    logic [31:0] dadoReg         [2];
    logic [1:0]  tamanho         [2];
    logic [31:0] mem_end         [2];
    logic        mem_le          [2];
    logic [31:0] mem_lerDado     [2];
    logic        mem_escreve     [2];
    logic [31:0] mem_escreveDado [2];
    logic        concluido       [2];
    logic        erro            [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          e_le   [2][NC];
    bit          e_we   [2][NC];
    bit          e_er   [2][NC];
    bit          e_busy [2][NC];
    bit          e_litv [2][NC];
    logic [31:0] e_addr [2][NC];
    logic [31:0] e_data [2][NC];
    logic [31:0] e_lita [2][NC];
    logic [31:0] e_litd [2][NC];
    logic [31:0] mem    [2][1024];
    logic [31:0] hold_a [2];
    logic [31:0] hold_d [2];
    int          rsp_c  [2];
    logic [31:0] rsp_a  [2];
    vec_t        vecs   [NV];

    controle_escrita_mem #(.LAT_LEITURA(1), .LARGURA_END(32)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n[0]), .req_valido(req_valido[0]), .req_pronto(req_pronto[0]),
        .endereco(endereco[0]), .dadoReg(dadoReg[0]), .tamanho(tamanho[0]),
        .mem_end(mem_end[0]), .mem_le(mem_le[0]), .mem_lerDado(mem_lerDado[0]),
        .mem_escreve(mem_escreve[0]), .mem_escreveDado(mem_escreveDado[0]),
        .concluido(concluido[0]), .erro(erro[0])
    );

    controle_escrita_mem #(.LAT_LEITURA(3), .LARGURA_END(32)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n[1]), .req_valido(req_valido[1]), .req_pronto(req_pronto[1]),
        .endereco(endereco[1]), .dadoReg(dadoReg[1]), .tamanho(tamanho[1]),
        .mem_end(mem_end[1]), .mem_le(mem_le[1]), .mem_lerDado(mem_lerDado[1]),
        .mem_escreve(mem_escreve[1]), .mem_escreveDado(mem_escreveDado[1]),
        .concluido(concluido[1]), .erro(erro[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_from(input int d, input int from);
        for (int c = from; c < NC; c++) begin
            e_le[d][c] = 0; e_we[d][c] = 0; e_er[d][c] = 0; e_busy[d][c] = 0; e_litv[d][c] = 0;
        end
    endtask

    // Model: from the request alone, decide when each strobe fires and with what word.
    task automatic schedule(input int d, input vec_t v, input int t);
        logic [31:0] wa, w;
        int k, nb, wc;
        bit bad;
        wa  = {v.a[31:2], 2'b00};
        k   = int'(v.a[1:0]);
        bad = (v.sz == 2'd3) || (v.sz == 2'd1 && v.a[0]) || (v.sz == 2'd2 && k != 0);
        if (t < 0 || t + 8 >= NC) return;
        if (bad) begin
            e_er[d][t+1] = 1; e_busy[d][t+1] = 1;
            return;
        end
        if (v.sz == 2'd2) begin
            w  = v.dt;
            wc = t + 1;
        end else begin
            w  = mem[d][wa[11:2]];
            nb = (v.sz == 2'd0) ? 1 : 2;
            for (int b = 0; b < nb; b++) w[8*(k+b) +: 8] = v.dt[8*b +: 8];
            wc = t + 2 + lat(d);
            e_le[d][t+1] = 1; e_addr[d][t+1] = wa;
        end
        for (int c = t + 1; c <= wc; c++) e_busy[d][c] = 1;
        e_we[d][wc] = 1; e_addr[d][wc] = wa; e_data[d][wc] = w;
        if (v.litv) begin
            e_litv[d][wc] = 1; e_lita[d][wc] = v.la; e_litd[d][wc] = v.ld;
        end
    endtask

    // Per-cycle compare plus memory responder (garbage outside the valid cycle).
    always @(negedge clk) begin
        bit xle, xwe, xer, xbusy;
        for (int d = 0; d < 2; d++) begin
            xle = 0; xwe = 0; xer = 0; xbusy = 0;
            if (!rst_n[d]) begin
                hold_a[d] = '0; hold_d[d] = '0; rsp_c[d] = -1;
            end else if (cyc < NC) begin
                xle = e_le[d][cyc]; xwe = e_we[d][cyc]; xer = e_er[d][cyc]; xbusy = e_busy[d][cyc];
                if (xle || xwe) hold_a[d] = e_addr[d][cyc];
                if (xwe) begin
                    hold_d[d] = e_data[d][cyc];
                    mem[d][hold_a[d][11:2]] = hold_d[d];
                end
                if (e_litv[d][cyc]) begin
                    check($sformatf("d%0d c%0d lit_addr", d, cyc), mem_end[d], e_lita[d][cyc]);
                    check($sformatf("d%0d c%0d lit_data", d, cyc), mem_escreveDado[d], e_litd[d][cyc]);
                end
            end
            check($sformatf("d%0d c%0d mem_le", d, cyc), 32'(mem_le[d]), 32'(xle));
            check($sformatf("d%0d c%0d mem_escreve", d, cyc), 32'(mem_escreve[d]), 32'(xwe));
            check($sformatf("d%0d c%0d concluido", d, cyc), 32'(concluido[d]), 32'(xwe));
            check($sformatf("d%0d c%0d erro", d, cyc), 32'(erro[d]), 32'(xer));
            check($sformatf("d%0d c%0d req_pronto", d, cyc), 32'(req_pronto[d]), 32'(!xbusy));
            check($sformatf("d%0d c%0d mem_end", d, cyc), mem_end[d], hold_a[d]);
            check($sformatf("d%0d c%0d mem_escreveDado", d, cyc), mem_escreveDado[d], hold_d[d]);
            if (rst_n[d] && mem_le[d]) begin
                rsp_c[d] = cyc + lat(d);
                rsp_a[d] = mem_end[d];
            end
            if (rsp_c[d] == cyc) mem_lerDado[d] = mem[d][rsp_a[d][11:2]];
            else                 mem_lerDado[d] = 32'hBAD0_0000 | 32'(cyc);
        end
    end

    task automatic issue(input int d, input vec_t v, input bit keep_valid, output int t);
        int w;
        @(negedge clk);
        endereco[d] = v.a; dadoReg[d] = v.dt; tamanho[d] = v.sz; req_valido[d] = 1'b1;
        w = 0;
        while (!req_pronto[d] && w < 20) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("d%0d accept_pronto", d), 32'(req_pronto[d]), 32'd1);
        t = req_pronto[d] ? cyc : -1;
        schedule(d, v, t);
        if (!keep_valid) begin
            @(negedge clk);
            req_valido[d] = 1'b0;
            endereco[d] = $urandom; dadoReg[d] = $urandom; tamanho[d] = 2'($urandom);
        end
    endtask

    task automatic run(input int d);
        int t;
        vec_t v;
        for (int i = 0; i < NV; i++)
            issue(d, vecs[i], (i + 1 < NV) && vecs[i+1].b2b, t);
        // Reset while waiting for read data: the pending write must vanish.
        v = '{32'h204, 32'h99, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0};
        issue(d, v, 1'b0, t);
        @(negedge clk);
        #2 rst_n[d] = 1'b0;
        clear_from(d, (t < 0) ? 0 : t + 3);
        #1;
        check($sformatf("d%0d rst mem_le", d), 32'(mem_le[d]), 32'd0);
        check($sformatf("d%0d rst mem_escreve", d), 32'(mem_escreve[d]), 32'd0);
        check($sformatf("d%0d rst concluido", d), 32'(concluido[d]), 32'd0);
        check($sformatf("d%0d rst erro", d), 32'(erro[d]), 32'd0);
        check($sformatf("d%0d rst req_pronto", d), 32'(req_pronto[d]), 32'd1);
        check($sformatf("d%0d rst mem_end", d), mem_end[d], 32'd0);
        check($sformatf("d%0d rst mem_escreveDado", d), mem_escreveDado[d], 32'd0);
        @(negedge clk);
        #2 rst_n[d] = 1'b1;
        v = '{32'h108, 32'h0BADF00D, 2'd2, 1'b0, 1'b1, 32'h108, 32'h0BADF00D};
        issue(d, v, 1'b0, t);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF};
        vecs[1]  = '{32'h203, 32'h000000AB, 2'd0, 1'b0, 1'b1, 32'h200, 32'hAB223344};
        vecs[2]  = '{32'h012, 32'hFFFF5A5A, 2'd1, 1'b0, 1'b1, 32'h010, 32'h5A5A3344};
        vecs[3]  = '{32'h013, 32'h00001234, 2'd1, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{32'h102, 32'h00005555, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{32'h040, 32'h00009999, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[6]  = '{32'h001, 32'h00000077, 2'd0, 1'b0, 1'b1, 32'h000, 32'h00007700};
        vecs[7]  = '{32'h202, 32'h000000CD, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[8]  = '{32'h200, 32'h00001234, 2'd1, 1'b1, 1'b1, 32'h200, 32'hABCD1234};
        vecs[9]  = '{32'h013, 32'h0000FFFF, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0};
        vecs[10] = '{32'h104, 32'hCAFEF00D, 2'd2, 1'b1, 1'b1, 32'h104, 32'hCAFEF00D};
        vecs[11] = '{32'h311, 32'h0000005E, 2'd0, 1'b0, 1'b1, 32'h310, 32'hA0B05ED0};
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) mem[d][i] = 32'h0;
            mem[d][32'h200 >> 2] = 32'h11223344;
            mem[d][32'h010 >> 2] = 32'h11223344;
            mem[d][32'h310 >> 2] = 32'hA0B0C0D0;
            clear_from(d, 0);
            rst_n[d] = 1'b0; req_valido[d] = 1'b0;
            endereco[d] = '0; dadoReg[d] = '0; tamanho[d] = '0; mem_lerDado[d] = '0;
            hold_a[d] = '0; hold_d[d] = '0; rsp_c[d] = -1; rsp_a[d] = '0;
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        fork
            run(0);
            run(1);
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_escrita_mem.md
Name: controle_escrita_mem

Overview:
Store-path engine for the datapath: takes a store request (register data, byte address, access size) and performs the data-memory write. Full-word stores are written directly. Byte and halfword stores use read-modify-write against a word-wide synchronous data memory. It is the write-side counterpart of the load/writeback path, driving memory instead of the register file.

Parameters:
LAT_LEITURA, 1, cycles from the mem_le cycle until mem_lerDado is valid (legal 1..4)
LARGURA_END, 32, width of endereco and mem_end

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valido  in  1  store request present
req_pronto  out  1  block idle, can accept a request
endereco  in  LARGURA_END  byte address of the store
dadoReg  in  32  register data to store (byte/half taken from low bits)
tamanho  in  2  00 byte, 01 halfword, 10 word, 11 reserved
mem_end  out  LARGURA_END  word address to memory, bits [1:0] always 0
mem_le  out  1  memory read strobe, one cycle
mem_lerDado  in  32  memory read data
mem_escreve  out  1  memory write strobe, one cycle
mem_escreveDado  out  32  full word to write
concluido  out  1  one-cycle pulse: store completed
erro  out  1  one-cycle pulse: misaligned or reserved size, nothing written

Behaviour:
- Acceptance: a request is accepted on a rising edge where req_valido=1 and req_pronto=1; call this cycle T.
  - endereco, dadoReg and tamanho are latched at T.
  - Later input changes are ignored until the next acceptance.
- req_pronto=1 only in state OCIOSO. No request queueing.
- Little-endian byte lanes: byte k occupies bits [8k+7:8k], with k = endereco[1:0].
- States: OCIOSO, LEITURA, ESPERA, ESCRITA, ERRO.
- OCIOSO, on acceptance:
  - tamanho=11 -> ERRO.
  - halfword with endereco[0]=1 -> ERRO.
  - word with endereco[1:0]!=0 -> ERRO.
  - word, aligned -> ESCRITA.
  - byte, or aligned halfword -> LEITURA.
- LEITURA (1 cycle): mem_le=1, mem_end = {endereco[MSB:2],2'b00}; then -> ESPERA.
- ESPERA: counts LAT_LEITURA-1 cycles. mem_lerDado is valid in the cycle LAT_LEITURA after the LEITURA cycle and is sampled at the end of that cycle. The sampled word is merged with dadoReg: only the addressed byte or halfword lanes are replaced, other lanes are preserved. Then -> ESCRITA.
- ESCRITA (1 cycle): mem_escreve=1, concluido=1, mem_end = word address, mem_escreveDado = merged word (word store: dadoReg unchanged); then -> OCIOSO.
- ERRO (1 cycle): erro=1, no mem_le/mem_escreve; then -> OCIOSO.
- Latency with LAT_LEITURA=1:
  - word write/concluido at T+1.
  - sub-word mem_le at T+1, data valid T+2, write/concluido at T+3.
  - erro at T+1.
  - req_pronto returns the cycle after ESCRITA/ERRO.
- Outputs outside their active states: mem_le, mem_escreve, concluido, erro = 0. mem_end and mem_escreveDado hold their last value.
- Reset (any time, including mid-operation):
  - state OCIOSO.
  - mem_le, mem_escreve, concluido, erro = 0.
  - mem_end, mem_escreveDado, internal latches = 0.
  - req_pronto = 1.
  - A read in flight is abandoned and its returning data ignored; no write is issued for the aborted request.
- mem_le and mem_escreve are never asserted in the same cycle.
- Back-to-back requests: req_valido held high yields one accept per completed operation.

Test Plan:
- Word store: endereco=0x100, dadoReg=0xDEADBEEF, tamanho=10, accept at T -> T+1: mem_escreve=1, mem_end=0x100, mem_escreveDado=0xDEADBEEF, concluido=1; no mem_le.
- Byte store: endereco=0x203, dadoReg=0x000000AB, tamanho=00; memory returns 0x11223344 -> mem_le at T+1 with mem_end=0x200; T+3: mem_escreveDado=0xAB223344, concluido=1.
- Halfword store: endereco=0x012, dadoReg=0xFFFF5A5A, tamanho=01; memory returns 0x11223344 -> write 0x5A5A3344 to 0x010 at T+3.
- Errors: halfword at 0x013, word at 0x102, tamanho=11 -> erro=1 at T+1; no mem_le/mem_escreve; req_pronto=1 at T+2.
- LAT_LEITURA=3, byte store at 0x001 with memory 0x00000000 and data 0x77 -> write 0x00007700 at T+5.
- rst_n low during ESPERA -> no mem_escreve afterwards; req_pronto=1; all strobes 0; next word store completes normally.
